// File: rtl/pipe_stage.sv
// Two-entry skid-buffer pipeline stage with registered ready.
// Tracks held payloads and counts cycles stalled by downstream.
module pipe_stage #(
    parameter int DATA_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = '0,
    parameter int CNT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [1:0]            occupancy,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t state;
    state_t state_nxt;

    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;

    logic xfer_in;
    logic xfer_out;
    logic load_main;
    logic load_skid;
    logic main_from_skid;

    assign xfer_in  = in_valid & in_ready;
    assign xfer_out = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (xfer_in) state_nxt = FULL;
                end
                FULL: begin
                    if (xfer_out && !xfer_in) state_nxt = EMPTY;
                    else if (xfer_in && !xfer_out) state_nxt = SKID;
                end
                SKID: begin
                    if (xfer_out) state_nxt = FULL;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // ready comes from state alone so out_ready never reaches in_ready
    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = 2'd0;
        unique case (state)
            EMPTY: ;
            FULL: begin
                out_valid = 1'b1;
                occupancy = 2'd1;
            end
            SKID: begin
                in_ready  = 1'b0;
                out_valid = 1'b1;
                occupancy = 2'd2;
            end
            default: ;
        endcase
    end

    always_comb begin
        load_main = 1'b0;
        load_skid = 1'b0;
        main_from_skid = 1'b0;
        unique case (state)
            EMPTY: load_main = xfer_in;
            FULL: begin
                load_main = xfer_in & xfer_out;
                load_skid = xfer_in & ~xfer_out;
            end
            SKID: main_from_skid = xfer_out;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_q <= BUBBLE_VALUE;
            skid_q <= BUBBLE_VALUE;
        end else begin
            if (load_main) begin
                main_q <= in_data;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    assign out_data = out_valid ? main_q : BUBBLE_VALUE;

    // flush deliberately leaves the stall statistic alone
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready
                     && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: vector table, directed corner cases,
// and random traffic against a queue-based reference model.
module tb_pipe_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready = 1'b0;
    logic [1:0]  occupancy;
    logic [7:0]  stall_cnt;

    int total = 0;
    int bad = 0;

    logic [15:0] q[$];
    int m_stall = 0;

    typedef struct {
        logic        iv;
        logic [15:0] d;
        logic        ordy;
        logic        ov;
        logic [15:0] od;
        logic        ir;
        logic [1:0]  occ;
        logic [7:0]  st;
    } vec_t;

    vec_t vt[13];

    pipe_stage #(
        .DATA_WIDTH(16),
        .BUBBLE_VALUE(16'h0000),
        .CNT_WIDTH(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    task automatic cyc(input logic iv, input logic [15:0] d,
                       input logic ordy, input logic fl,
                       input logic rs);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        reset     = rs;
        @(posedge clk);
        #1;
    endtask

    // Capacity-2 FIFO view of the stage, stepped once per edge.
    task automatic model_edge(input logic iv, input logic [15:0] d,
                              input logic ordy, input logic fl,
                              input logic rs);
        bit acc;
        if (rs) begin
            q.delete();
            m_stall = 0;
            return;
        end
        if (q.size() > 0 && !ordy && m_stall < 255) m_stall++;
        if (fl) begin
            q.delete();
            return;
        end
        acc = iv && (q.size() < 2);
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (acc) q.push_back(d);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, ".ov"}, out_valid, 1'b0);
        chk({nm, ".od"}, out_data, 16'h0000);
        chk({nm, ".ir"}, in_ready, 1'b1);
        chk({nm, ".occ"}, occupancy, 2'd0);
    endtask

    initial begin
        vt[0]  = '{1'b1, 16'h1000, 1'b1, 1'b1, 16'h1000, 1'b1, 2'd1, 8'd0};
        vt[1]  = '{1'b1, 16'h1001, 1'b1, 1'b1, 16'h1001, 1'b1, 2'd1, 8'd0};
        vt[2]  = '{1'b1, 16'h1002, 1'b1, 1'b1, 16'h1002, 1'b1, 2'd1, 8'd0};
        vt[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 2'd0, 8'd0};
        vt[4]  = '{1'b1, 16'h00AA, 1'b0, 1'b1, 16'h00AA, 1'b1, 2'd1, 8'd0};
        vt[5]  = '{1'b1, 16'h00BB, 1'b0, 1'b1, 16'h00AA, 1'b0, 2'd2, 8'd1};
        vt[6]  = '{1'b1, 16'h00CC, 1'b1, 1'b1, 16'h00BB, 1'b1, 2'd1, 8'd1};
        vt[7]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 2'd0, 8'd1};
        vt[8]  = '{1'b1, 16'h0123, 1'b0, 1'b1, 16'h0123, 1'b1, 2'd1, 8'd1};
        vt[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0123, 1'b1, 2'd1, 8'd2};
        vt[10] = '{1'b1, 16'h0456, 1'b1, 1'b1, 16'h0456, 1'b1, 2'd1, 8'd2};
        vt[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0456, 1'b1, 2'd1, 8'd3};
        vt[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 2'd0, 8'd3};

        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk_idle("reset");
        chk("reset.st", stall_cnt, 8'd0);

        for (int i = 0; i < 13; i++) begin
            cyc(vt[i].iv, vt[i].d, vt[i].ordy, 1'b0, 1'b0);
            chk($sformatf("vec%0d.ov", i), out_valid, vt[i].ov);
            chk($sformatf("vec%0d.od", i), out_data, vt[i].od);
            chk($sformatf("vec%0d.ir", i), in_ready, vt[i].ir);
            chk($sformatf("vec%0d.occ", i), occupancy, vt[i].occ);
            chk($sformatf("vec%0d.st", i), stall_cnt, vt[i].st);
        end

        // flush while in SKID with a new payload offered
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0);
        chk("flush.pre_occ", occupancy, 2'd2);
        cyc(1'b1, 16'h0033, 1'b0, 1'b1, 1'b0);
        chk_idle("flush");
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk_idle("flush.after");
        chk("flush.st", stall_cnt, 8'd2);

        // stall counter saturation
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 16'h0055, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        end
        chk("stall.sat", stall_cnt, 8'hFF);
        chk("stall.od", out_data, 16'h0055);
        cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        chk("stall.flush", stall_cnt, 8'hFF);
        chk("stall.flush_ov", out_valid, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("stall.reset", stall_cnt, 8'h00);

        // reset while in SKID
        cyc(1'b1, 16'h0101, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 16'h0202, 1'b0, 1'b0, 1'b0);
        chk("rstmid.pre_occ", occupancy, 2'd2);
        chk("rstmid.pre_ir", in_ready, 1'b0);
        cyc(1'b1, 16'h0777, 1'b1, 1'b0, 1'b1);
        chk_idle("rstmid");
        chk("rstmid.st", stall_cnt, 8'd0);
        cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk_idle("rstmid.after");

        // random traffic against the FIFO model
        cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        model_edge(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10000; i++) begin
            logic        iv;
            logic [15:0] d;
            logic        ordy;
            logic        fl;
            logic        rs;
            iv   = 1'($urandom_range(0, 1));
            d    = 16'($urandom);
            ordy = 1'($urandom_range(0, 1));
            fl   = ($urandom_range(0, 49) == 0);
            rs   = ($urandom_range(0, 999) == 0);
            model_edge(iv, d, ordy, fl, rs);
            cyc(iv, d, ordy, fl, rs);
            chk("rand.ov", out_valid, q.size() > 0);
            chk("rand.occ", occupancy, q.size());
            chk("rand.ir", in_ready, q.size() < 2);
            chk("rand.od", out_data,
                (q.size() > 0) ? q[0] : 16'h0000);
            chk("rand.st", stall_cnt, m_stall);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
